// File: rtl/issue_if.sv
// Decode / writeback / branch-resolve handshake bundle for the issue controller.
interface issue_if #(
  parameter int unsigned RIDX_W = 5
) ();
  logic              dec_valid;
  logic [RIDX_W-1:0] dec_rs1;
  logic [RIDX_W-1:0] dec_rs2;
  logic [RIDX_W-1:0] dec_rd;
  logic              dec_rs1_used;
  logic              dec_rs2_used;
  logic              dec_wr_rd;
  logic              dec_is_branch;
  logic              dec_ready;
  logic              issue;
  logic              wb_valid;
  logic [RIDX_W-1:0] wb_rd;
  logic              br_resolve;
  logic              br_taken;
  logic              flush;

  // Pipeline side: drives decode, writeback and branch-resolve information.
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used,
    output dec_wr_rd, dec_is_branch, wb_valid, wb_rd, br_resolve, br_taken,
    input  dec_ready, issue, flush
  );

  // Issue controller side.
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used,
    input  dec_wr_rd, dec_is_branch, wb_valid, wb_rd, br_resolve, br_taken,
    output dec_ready, issue, flush
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard, in-flight write window and
// a branch-wait state machine that stalls decode and pulses flush on redirects.
module issue_ctrl #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned RIDX_W       = 5,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  issue_if.slave           bus,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] inflight,
  output logic             sb_err
);

  typedef enum logic [1:0] {StRun, StBrWait, StFlush} state_e;

  state_e           state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             sb_err_q, sb_err_d;

  logic raw1, raw2, waw, full, stall, do_issue, set_en, wb_ok;

  // Hazard detection from registered state only; no writeback bypass.
  always_comb begin
    raw1     = bus.dec_rs1_used && (bus.dec_rs1 != '0) && busy_q[bus.dec_rs1];
    raw2     = bus.dec_rs2_used && (bus.dec_rs2 != '0) && busy_q[bus.dec_rs2];
    waw      = bus.dec_wr_rd && (bus.dec_rd != '0) && busy_q[bus.dec_rd];
    full     = bus.dec_wr_rd && (bus.dec_rd != '0) && (inflight_q == CNT_W'(MAX_INFLIGHT));
    stall    = (state_q != StRun) || raw1 || raw2 || waw || full;
    do_issue = bus.dec_valid && !stall;
    set_en   = do_issue && bus.dec_wr_rd && (bus.dec_rd != '0);
    wb_ok    = bus.wb_valid && (bus.wb_rd != '0) && busy_q[bus.wb_rd];
  end

  assign bus.dec_ready = ~stall;
  assign bus.issue     = do_issue;
  assign bus.flush     = (state_q == StFlush);
  assign busy          = busy_q;
  assign inflight      = inflight_q;
  assign sb_err        = sb_err_q;

  // Scoreboard, in-flight count and error flag next state; set beats clear.
  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    sb_err_d   = sb_err_q | (bus.wb_valid & ~wb_ok);
    if (wb_ok) busy_d[bus.wb_rd] = 1'b0;
    if (set_en) busy_d[bus.dec_rd] = 1'b1;
    unique case ({set_en, wb_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Branch state machine next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (do_issue && bus.dec_is_branch) state_d = StBrWait;
      StBrWait: if (bus.br_resolve) state_d = bus.br_taken ? StFlush : StRun;
      StFlush:  state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      busy_q     <= '0;
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized
// traffic against a behavioural scoreboard model.
module tb_issue_ctrl;
  localparam int unsigned NREGS = 32;
  localparam int unsigned MAXF  = 4;
  localparam int ModeRun = 0, ModeWait = 1, ModeFlush = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] busy;
  logic [2:0]  inflight;
  logic        sb_err;
  int          checks = 0;
  int          errors = 0;

  // Behavioural model: set of pending registers, mode and sticky error.
  bit [31:0] mbusy;
  int        mmode;
  bit        merr;

  issue_if #(.RIDX_W(5)) bus ();

  issue_ctrl #(.NREGS(NREGS), .RIDX_W(5), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
    bus.dec_rs1_used = 0; bus.dec_rs2_used = 0; bus.dec_wr_rd = 0; bus.dec_is_branch = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.br_resolve = 0; bus.br_taken = 0;
  endtask

  task automatic set_dec(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input bit br);
    bus.dec_valid = v; bus.dec_rs1 = 5'(rs1); bus.dec_rs1_used = u1;
    bus.dec_rs2 = 5'(rs2); bus.dec_rs2_used = u2; bus.dec_rd = 5'(rd);
    bus.dec_wr_rd = wr; bus.dec_is_branch = br;
  endtask

  // Outstanding writes equal the number of pending registers.
  function automatic int m_inflight();
    return $countones(mbusy);
  endfunction

  function automatic bit m_ready();
    bit blocked;
    blocked = (mmode != ModeRun);
    if (bus.dec_rs1_used && bus.dec_rs1 != 0 && mbusy[bus.dec_rs1]) blocked = 1;
    if (bus.dec_rs2_used && bus.dec_rs2 != 0 && mbusy[bus.dec_rs2]) blocked = 1;
    if (bus.dec_wr_rd && bus.dec_rd != 0 && (mbusy[bus.dec_rd] || m_inflight() == MAXF))
      blocked = 1;
    return !blocked;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic m_step();
    bit iss;
    if (rst) begin
      mbusy = 0; mmode = ModeRun; merr = 0;
      return;
    end
    iss = bus.dec_valid && m_ready();
    if (bus.wb_valid) begin
      if (bus.wb_rd != 0 && mbusy[bus.wb_rd]) mbusy[bus.wb_rd] = 0;
      else merr = 1;
    end
    if (iss && bus.dec_wr_rd && bus.dec_rd != 0) mbusy[bus.dec_rd] = 1;
    case (mmode)
      ModeRun:  if (iss && bus.dec_is_branch) mmode = ModeWait;
      ModeWait: if (bus.br_resolve) mmode = bus.br_taken ? ModeFlush : ModeRun;
      default:  mmode = ModeRun;
    endcase
  endtask

  task automatic test_reset();
    idle(); rst = 1; cyc(); rst = 0; #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.dec_ready); end
  endtask

  task automatic test_raw();
    set_dec(1, 1, 1, 2, 1, 5, 1, 0); #1;
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b want 1", bus.issue); end
    cyc();
    checks++; if (busy[5] !== 1'b1 || inflight !== 3'd1) begin errors++; $display("FAIL raw_busy5: busy %h inflight %0d want bit5 and 1", busy, inflight); end
    set_dec(1, 5, 1, 2, 1, 6, 1, 0); #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", bus.dec_ready); end
    cyc();
    bus.wb_valid = 1; bus.wb_rd = 5; #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b want 0", bus.dec_ready); end
    cyc();
    bus.wb_valid = 0; #1;
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_release_issue: got %b want 1", bus.issue); end
    cyc();
    bus.dec_valid = 0; bus.wb_valid = 1; bus.wb_rd = 6; cyc();
    bus.wb_valid = 0; #1;
    checks++; if (busy !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL raw_drain: busy %h inflight %0d want 0 0", busy, inflight); end
  endtask

  task automatic test_window();
    for (int r = 1; r <= 4; r++) begin
      set_dec(1, 0, 0, 0, 0, r, 1, 0); cyc();
    end
    set_dec(1, 0, 0, 0, 0, 6, 1, 0); #1;
    checks++; if (bus.dec_ready !== 1'b0 || inflight !== 3'd4) begin errors++; $display("FAIL window_full: ready %b inflight %0d want 0 4", bus.dec_ready, inflight); end
    bus.wb_valid = 1; bus.wb_rd = 2; cyc();
    bus.wb_valid = 0; #1;
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL window_issue_after_wb: got %b want 1", bus.issue); end
    cyc();
    bus.dec_valid = 0; #1;
    checks++; if (inflight !== 3'd4 || busy !== 32'h0000_005A) begin errors++; $display("FAIL window_refill: inflight %0d busy %h want 4 5a", inflight, busy); end
  endtask

  // Runs with the window still full from test_window.
  task automatic test_zero();
    set_dec(1, 0, 1, 0, 0, 0, 1, 0); #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", bus.dec_ready); end
    cyc();
    bus.dec_valid = 0; #1;
    checks++; if (inflight !== 3'd4 || busy[0] !== 1'b0) begin errors++; $display("FAIL zero_state: inflight %0d busy0 %b want 4 0", inflight, busy[0]); end
    foreach (busy[i]) if (busy[i]) begin
      bus.wb_valid = 1; bus.wb_rd = 5'(i); cyc();
    end
    bus.wb_valid = 0; #1;
    checks++; if (inflight !== 3'd0 || busy !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL zero_drain: inflight %0d busy %h err %b want 0 0 0", inflight, busy, sb_err); end
  endtask

  task automatic test_branch();
    set_dec(1, 0, 0, 0, 0, 0, 0, 1); #1;
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL br_issue: got %b want 1", bus.issue); end
    cyc();
    bus.dec_is_branch = 0; #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL br_wait_stall: got %b want 0", bus.dec_ready); end
    cyc();
    bus.br_resolve = 1; bus.br_taken = 1; cyc();
    bus.br_resolve = 0; bus.br_taken = 0; #1;
    checks++; if (bus.flush !== 1'b1 || bus.dec_ready !== 1'b0) begin errors++; $display("FAIL br_flush: flush %b ready %b want 1 0", bus.flush, bus.dec_ready); end
    cyc();
    checks++; if (bus.flush !== 1'b0 || bus.dec_ready !== 1'b1) begin errors++; $display("FAIL br_after_flush: flush %b ready %b want 0 1", bus.flush, bus.dec_ready); end
    bus.dec_is_branch = 1; cyc();
    bus.dec_is_branch = 0; bus.br_resolve = 1; bus.br_taken = 0; cyc();
    bus.br_resolve = 0; #1;
    checks++; if (bus.flush !== 1'b0 || bus.dec_ready !== 1'b1) begin errors++; $display("FAIL br_not_taken: flush %b ready %b want 0 1", bus.flush, bus.dec_ready); end
    bus.dec_valid = 0;
  endtask

  task automatic test_jal();
    set_dec(1, 0, 0, 0, 0, 3, 1, 0); cyc();
    set_dec(1, 0, 0, 0, 0, 1, 1, 1); cyc();
    bus.dec_valid = 0; bus.br_resolve = 1; bus.br_taken = 1; #1;
    checks++; if (busy !== 32'h0000_000A || inflight !== 3'd2) begin errors++; $display("FAIL jal_pending: busy %h inflight %0d want a 2", busy, inflight); end
    cyc();
    bus.br_resolve = 0; bus.br_taken = 0; #1;
    checks++; if (bus.flush !== 1'b1 || busy[3] !== 1'b1) begin errors++; $display("FAIL jal_flush: flush %b busy3 %b want 1 1", bus.flush, busy[3]); end
    bus.wb_valid = 1; bus.wb_rd = 3; cyc();
    bus.wb_valid = 0; #1;
    checks++; if (busy[3] !== 1'b0 || inflight !== 3'd1) begin errors++; $display("FAIL jal_wb3: busy3 %b inflight %0d want 0 1", busy[3], inflight); end
    bus.wb_valid = 1; bus.wb_rd = 1; cyc();
    bus.wb_valid = 0;
  endtask

  task automatic test_sb_err();
    bus.wb_valid = 1; bus.wb_rd = 7; cyc();
    bus.wb_valid = 0; cyc(); cyc();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky: got %b want 1", sb_err); end
    set_dec(1, 0, 0, 0, 0, 9, 1, 0); cyc();
    set_dec(1, 0, 0, 0, 0, 10, 1, 1); cyc();
    bus.dec_valid = 0; #1;
    checks++; if (busy !== 32'h0000_0600 || bus.dec_ready !== 1'b0) begin errors++; $display("FAIL rst_pre: busy %h ready %b want 600 0", busy, bus.dec_ready); end
    rst = 1; cyc();
    rst = 0; #1;
    checks++; if (busy !== 32'h0 || inflight !== 3'd0 || sb_err !== 1'b0 || bus.flush !== 1'b0 || bus.dec_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_branch: busy %h infl %0d err %b flush %b ready %b want 0 0 0 0 1", busy, inflight, sb_err, bus.flush, bus.dec_ready);
    end
  endtask

  task automatic test_random();
    int q[$];
    idle(); rst = 1; m_step(); cyc(); rst = 0;
    for (int n = 0; n < 600; n++) begin
      set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      q.delete();
      for (int i = 1; i < 32; i++) if (mbusy[i]) q.push_back(i);
      bus.wb_valid = 0; bus.wb_rd = 0;
      if ($urandom_range(0, 99) < 3) begin
        bus.wb_valid = 1; bus.wb_rd = 5'($urandom_range(0, 31));
      end else if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.wb_valid = 1; bus.wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      bus.br_resolve = $urandom_range(0, 2) == 0;
      bus.br_taken = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (bus.dec_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", n, bus.dec_ready, m_ready()); end
      checks++; if (bus.issue !== (bus.dec_valid && m_ready())) begin errors++; $display("FAIL rnd_issue @%0d: got %b want %b", n, bus.issue, bus.dec_valid && m_ready()); end
      checks++; if (bus.flush !== (mmode == ModeFlush)) begin errors++; $display("FAIL rnd_flush @%0d: got %b want %b", n, bus.flush, mmode == ModeFlush); end
      checks++; if (busy !== mbusy) begin errors++; $display("FAIL rnd_busy @%0d: got %h want %h", n, busy, mbusy); end
      checks++; if (inflight !== 3'(m_inflight())) begin errors++; $display("FAIL rnd_inflight @%0d: got %0d want %0d", n, inflight, m_inflight()); end
      checks++; if (sb_err !== merr) begin errors++; $display("FAIL rnd_sb_err @%0d: got %b want %b", n, sb_err, merr); end
      m_step();
      cyc();
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_window();
    test_zero();
    test_branch();
    test_jal();
    test_sb_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
